// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Round-robin arbiter in front of the SDRAM controller. Grants one of
//   NUM_MASTERS masters, captures its transaction onto the sdram_* port
//   tagged with ID (index+1), holds it until the controller reports
//   completion, and routes valid/complete pulses plus read data back.
//
// Ports
//   clock, reset_n        system clock, async active-low reset
//   m_req/m_write/m_burst per-master request, write flag, burst flag
//   m_address/m_wdata     per-master packed address (26b) and data (32b)
//   m_byte_en             per-master packed byte enables (4b)
//   m_ack, m_rvalid       per-master one-cycle pulses
//   m_rdata               registered read data shared by all masters
//   sdram_*               request port to the controller
//   sdram_rdata/valid     read data and ID-tagged valid from controller
//   sdram_complete        ID-tagged completion from controller
//
// FSM states
//   state      | meaning
//   ST_IDLE    | arbitrate; grant registers request next cycle
//   ST_BUSY    | hold captured transaction until matching complete
//   ST_RELEASE | one dead cycle so the acked master's stale req is not regranted

module sdram_arbiter #(
    parameter int NUM_MASTERS = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [26*NUM_MASTERS-1:0] m_address,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_byte_en,
    input  logic [NUM_MASTERS-1:0]    m_burst,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [NUM_MASTERS-1:0]    m_rvalid,
    output logic [31:0]               m_rdata,
    output logic                      sdram_request,
    output logic [3:0]                sdram_master,
    output logic                      sdram_write,
    output logic [25:0]               sdram_address,
    output logic [31:0]               sdram_wdata,
    output logic [3:0]                sdram_byte_en,
    output logic                      sdram_burst,
    input  logic [31:0]               sdram_rdata,
    input  logic [3:0]                sdram_valid,
    input  logic [3:0]                sdram_complete
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              last_grant_q, last_grant_d;
    logic                    sdram_request_q, sdram_request_d;
    logic [3:0]              sdram_master_q, sdram_master_d;
    logic                    sdram_write_q, sdram_write_d;
    logic [25:0]             sdram_address_q, sdram_address_d;
    logic [31:0]             sdram_wdata_q, sdram_wdata_d;
    logic [3:0]              sdram_byte_en_q, sdram_byte_en_d;
    logic                    sdram_burst_q, sdram_burst_d;
    logic [NUM_MASTERS-1:0]  m_ack_q, m_ack_d;
    logic [NUM_MASTERS-1:0]  m_rvalid_q, m_rvalid_d;
    logic [31:0]             m_rdata_q, m_rdata_d;

    logic                    win_found;
    logic [3:0]              win_idx;
    logic [25:0]             win_addr;

    // Scan last_grant+1, last_grant+2, ... with wrap; first requester wins,
    // so the previous winner is always checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant_q;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!win_found && m_req[(int'(last_grant_q) + k) % NUM_MASTERS]) begin
                win_found = 1'b1;
                win_idx   = 4'((int'(last_grant_q) + k) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        win_addr = m_address[int'(win_idx)*26 +: 26];
    end

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        sdram_request_d = sdram_request_q;
        sdram_master_d  = sdram_master_q;
        sdram_write_d   = sdram_write_q;
        sdram_address_d = sdram_address_q;
        sdram_wdata_d   = sdram_wdata_q;
        sdram_byte_en_d = sdram_byte_en_q;
        sdram_burst_d   = sdram_burst_q;
        m_ack_d         = '0;
        m_rvalid_d      = '0;
        m_rdata_d       = m_rdata_q;

        case (state_q)
            ST_IDLE: begin
                sdram_request_d = 1'b0;
                if (win_found) begin
                    sdram_request_d = 1'b1;
                    sdram_master_d  = win_idx + 4'd1;
                    sdram_write_d   = m_write[win_idx];
                    sdram_address_d = {win_addr[25:2], 2'b00};
                    sdram_wdata_d   = m_wdata[int'(win_idx)*32 +: 32];
                    sdram_byte_en_d = m_byte_en[int'(win_idx)*4 +: 4];
                    sdram_burst_d   = m_burst[win_idx];
                    last_grant_d    = win_idx;
                    state_d         = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Only the granted ID completes; captured fields stay put
                // through RELEASE for the controller's delayed upper-half write.
                if (sdram_complete == sdram_master_q) begin
                    sdram_request_d = 1'b0;
                    state_d         = ST_RELEASE;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (sdram_master_q == 4'(i + 1)) begin
                            m_ack_d[i] = 1'b1;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d         = ST_IDLE;
                sdram_request_d = 1'b0;
            end
        endcase

        // Read return is independent of the FSM: burst tails may land after ack.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sdram_valid == 4'(i + 1)) begin
                m_rvalid_d[i] = 1'b1;
            end
        end
        if (sdram_valid != 4'd0) begin
            m_rdata_d = sdram_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= 4'(NUM_MASTERS - 1);
            sdram_request_q <= 1'b0;
            sdram_master_q  <= 4'd0;
            sdram_write_q   <= 1'b0;
            sdram_address_q <= 26'd0;
            sdram_wdata_q   <= 32'd0;
            sdram_byte_en_q <= 4'd0;
            sdram_burst_q   <= 1'b0;
            m_ack_q         <= '0;
            m_rvalid_q      <= '0;
            m_rdata_q       <= 32'd0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            sdram_request_q <= sdram_request_d;
            sdram_master_q  <= sdram_master_d;
            sdram_write_q   <= sdram_write_d;
            sdram_address_q <= sdram_address_d;
            sdram_wdata_q   <= sdram_wdata_d;
            sdram_byte_en_q <= sdram_byte_en_d;
            sdram_burst_q   <= sdram_burst_d;
            m_ack_q         <= m_ack_d;
            m_rvalid_q      <= m_rvalid_d;
            m_rdata_q       <= m_rdata_d;
        end
    end

    assign m_ack         = m_ack_q;
    assign m_rvalid      = m_rvalid_q;
    assign m_rdata       = m_rdata_q;
    assign sdram_request = sdram_request_q;
    assign sdram_master  = sdram_master_q;
    assign sdram_write   = sdram_write_q;
    assign sdram_address = sdram_address_q;
    assign sdram_wdata   = sdram_wdata_q;
    assign sdram_byte_en = sdram_byte_en_q;
    assign sdram_burst   = sdram_burst_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Drives masters and a controller model with directed and random traffic.
//   Expected grants come from a round-robin pick over the request mask;
//   expected read returns come from the ID decode of each valid pulse.

module tb_sdram_arbiter;

    localparam int NM = 4;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [NM-1:0]        m_req;
    logic [NM-1:0]        m_write;
    logic [26*NM-1:0]     m_address;
    logic [32*NM-1:0]     m_wdata;
    logic [4*NM-1:0]      m_byte_en;
    logic [NM-1:0]        m_burst;
    logic [NM-1:0]        m_ack;
    logic [NM-1:0]        m_rvalid;
    logic [31:0]          m_rdata;
    logic                 sdram_request;
    logic [3:0]           sdram_master;
    logic                 sdram_write;
    logic [25:0]          sdram_address;
    logic [31:0]          sdram_wdata;
    logic [3:0]           sdram_byte_en;
    logic                 sdram_burst;
    logic [31:0]          sdram_rdata;
    logic [3:0]           sdram_valid;
    logic [3:0]           sdram_complete;

    sdram_arbiter #(.NUM_MASTERS(NM)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .m_req          (m_req),
        .m_write        (m_write),
        .m_address      (m_address),
        .m_wdata        (m_wdata),
        .m_byte_en      (m_byte_en),
        .m_burst        (m_burst),
        .m_ack          (m_ack),
        .m_rvalid       (m_rvalid),
        .m_rdata        (m_rdata),
        .sdram_request  (sdram_request),
        .sdram_master   (sdram_master),
        .sdram_write    (sdram_write),
        .sdram_address  (sdram_address),
        .sdram_wdata    (sdram_wdata),
        .sdram_byte_en  (sdram_byte_en),
        .sdram_burst    (sdram_burst),
        .sdram_rdata    (sdram_rdata),
        .sdram_valid    (sdram_valid),
        .sdram_complete (sdram_complete)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           last_g;
    logic [NM-1:0] req_mask;
    logic [31:0]  exp_rdata;

    logic         f_write [NM];
    logic [25:0]  f_addr  [NM];
    logic [31:0]  f_wdata [NM];
    logic [3:0]   f_be    [NM];
    logic         f_burst [NM];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int pick(input int last, input logic [NM-1:0] mask);
        for (int k = 1; k <= NM; k++) begin
            if (mask[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    task automatic drive_fields();
        for (int i = 0; i < NM; i++) begin
            m_write[i]           = f_write[i];
            m_address[i*26 +: 26] = f_addr[i];
            m_wdata[i*32 +: 32]   = f_wdata[i];
            m_byte_en[i*4 +: 4]   = f_be[i];
            m_burst[i]           = f_burst[i];
        end
        m_req = req_mask;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NM; i++) begin
            f_write[i] = 1'($urandom);
            f_addr[i]  = 26'($urandom) & 26'h3FF_FFFC;
            f_wdata[i] = $urandom;
            f_be[i]    = 4'($urandom);
            f_burst[i] = 1'($urandom);
        end
    endtask

    // One controller cycle: drive complete/valid/rdata, clock, check returns.
    task automatic step(input logic [3:0] cpl, input logic [3:0] vld,
                        input logic [31:0] data, input logic [NM-1:0] exp_ack);
        logic [NM-1:0] exp_rv;
        sdram_complete = cpl;
        sdram_valid    = vld;
        sdram_rdata    = data;
        tick();
        exp_rv = '0;
        if (vld >= 4'd1 && int'(vld) <= NM) exp_rv[int'(vld) - 1] = 1'b1;
        if (vld != 4'd0) exp_rdata = data;
        chk("m_rvalid", 64'(m_rvalid), 64'(exp_rv));
        chk("m_rdata", 64'(m_rdata), 64'(exp_rdata));
        chk("m_ack", 64'(m_ack), 64'(exp_ack));
        sdram_complete = 4'd0;
        sdram_valid    = 4'd0;
    endtask

    // mode 0: random busy traffic, 1: 8-beat burst return, 2: wrong-ID complete
    task automatic txn(input logic [NM-1:0] add, input int mode);
        int          g;
        logic        e_w, e_b;
        logic [25:0] e_a;
        logic [31:0] e_d;
        logic [3:0]  e_be, c;
        int          n;
        req_mask = req_mask | add;
        drive_fields();
        g = pick(last_g, req_mask);
        if (g < 0) begin
            tick();
            chk("idle_req", 64'(sdram_request), 64'd0);
            return;
        end
        e_w = f_write[g]; e_a = {f_addr[g][25:2], 2'b00}; e_d = f_wdata[g];
        e_be = f_be[g]; e_b = f_burst[g];
        tick();
        chk("grant_req", 64'(sdram_request), 64'd1);
        chk("grant_id", 64'(sdram_master), 64'(g + 1));
        chk("grant_write", 64'(sdram_write), 64'(e_w));
        chk("grant_addr", 64'(sdram_address), 64'(e_a));
        chk("grant_wdata", 64'(sdram_wdata), 64'(e_d));
        chk("grant_be", 64'(sdram_byte_en), 64'(e_be));
        chk("grant_burst", 64'(sdram_burst), 64'(e_b));
        last_g = g;
        // master fields change while busy and must be ignored
        rand_fields();
        drive_fields();
        n = (mode == 1) ? 8 : (mode == 2) ? 1 : int'($urandom_range(0, 6));
        for (int k = 0; k < n; k++) begin
            if (mode == 1) begin
                step(4'd0, 4'(g + 1), 32'h1111_1111 * 32'(k + 1), '0);
            end else if (mode == 2) begin
                step(4'((g + 1) % NM + 1), 4'd0, $urandom, '0);
            end else begin
                c = 4'($urandom_range(1, 15));
                if (c == 4'(g + 1) || $urandom_range(0, 1) == 0) c = 4'd0;
                step(c, 4'($urandom_range(0, 15)), $urandom, '0);
            end
            chk("busy_req", 64'(sdram_request), 64'd1);
            chk("busy_id", 64'(sdram_master), 64'(g + 1));
            chk("busy_addr", 64'(sdram_address), 64'(e_a));
            chk("busy_wdata", 64'(sdram_wdata), 64'(e_d));
        end
        step(4'(g + 1), 4'd0, 32'd0, NM'(1) << g);
        chk("rel_req", 64'(sdram_request), 64'd0);
        chk("rel_wdata", 64'(sdram_wdata), 64'(e_d));
        chk("rel_be", 64'(sdram_byte_en), 64'(e_be));
        // RELEASE cycle: stale request still up, stray complete ignored
        step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, '0);
        chk("gap_req", 64'(sdram_request), 64'd0);
        req_mask[g] = 1'b0;
        m_req = req_mask;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req_mask = '0;
        last_g = NM - 1;
        exp_rdata = 32'd0;
        sdram_rdata = 32'd0; sdram_valid = 4'd0; sdram_complete = 4'd0;
        for (int i = 0; i < NM; i++) begin
            f_write[i] = 1'b0; f_addr[i] = 26'd0; f_wdata[i] = 32'd0;
            f_be[i] = 4'd0; f_burst[i] = 1'b0;
        end
        drive_fields();
        repeat (2) tick();
        chk("rst_req", 64'(sdram_request), 64'd0);
        chk("rst_id", 64'(sdram_master), 64'd0);
        chk("rst_addr", 64'(sdram_address), 64'd0);
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_rdata", 64'(m_rdata), 64'd0);
        reset_n = 1'b1;
        tick();

        // single read by master 0 at 0x100
        f_write[0] = 1'b0; f_addr[0] = 26'h000_0100; f_burst[0] = 1'b0;
        txn(4'b0001, 0);
        txn(4'b0000, 0);

        // all masters requesting, re-requesting after each ack
        rand_fields();
        for (int r = 0; r < 5; r++) txn(4'b1111, 0);
        while (req_mask != '0) txn(4'b0000, 0);

        // burst read by master 2
        rand_fields();
        f_write[2] = 1'b0; f_burst[2] = 1'b1;
        txn(4'b0100, 1);

        // write by master 1 with data change after grant
        rand_fields();
        f_write[1] = 1'b1; f_wdata[1] = 32'hDEAD_BEEF; f_be[1] = 4'b1100;
        txn(4'b0010, 0);

        // wrong-ID complete on grant ID 2
        rand_fields();
        txn(4'b0010, 2);

        for (int r = 0; r < 80; r++) begin
            rand_fields();
            txn(NM'($urandom), int'($urandom_range(0, 2)));
        end
        while (req_mask != '0) txn(4'b0000, 0);

        // reset in the middle of a transaction
        rand_fields();
        req_mask = 4'b0010;
        drive_fields();
        tick();
        chk("pre_rst_req", 64'(sdram_request), 64'd1);
        sdram_valid = 4'd2; sdram_complete = 4'd2;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(sdram_request), 64'd0);
        chk("mid_rst_id", 64'(sdram_master), 64'd0);
        chk("mid_rst_ack", 64'(m_ack), 64'd0);
        chk("mid_rst_rvalid", 64'(m_rvalid), 64'd0);
        tick();
        sdram_valid = 4'd0; sdram_complete = 4'd0;
        chk("in_rst_ack", 64'(m_ack), 64'd0);
        reset_n = 1'b1;
        last_g = NM - 1;
        exp_rdata = 32'd0;
        rand_fields();
        txn(4'b1111, 0);
        while (req_mask != '0) txn(4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Upstream neighbour of the SDRAM controller. Arbitrates NUM_MASTERS independent masters (CPU I/D caches, blitter, VGA) onto the controller's single request port using round-robin.
- Captures the winning master's transaction, tags it with a 4-bit master ID, and holds it stable until the controller reports completion.
- Routes the controller's valid and complete pulses, plus read data, back to the owning master.

Parameters:
- NUM_MASTERS, 4, number of master ports. Legal range 1..15. Master i carries ID i+1; ID 0 means "none".

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- m_req  in  NUM_MASTERS  per-master request, held high until m_ack seen
- m_write  in  NUM_MASTERS  per-master write flag
- m_address  in  26*NUM_MASTERS  per-master byte address; bits [1:0] ignored
- m_wdata  in  32*NUM_MASTERS  per-master write data
- m_byte_en  in  4*NUM_MASTERS  per-master byte enables
- m_burst  in  NUM_MASTERS  per-master 32-byte burst flag (reads only)
- m_ack  out  NUM_MASTERS  one-cycle pulse: transaction accepted/completed
- m_rvalid  out  NUM_MASTERS  one-cycle pulse: m_rdata valid for this master
- m_rdata  out  32  registered read data, shared by all masters
- sdram_request  out  1  to controller
- sdram_master  out  4  ID of granted master
- sdram_write  out  1
- sdram_address  out  26
- sdram_wdata  out  32
- sdram_byte_en  out  4
- sdram_burst  out  1
- sdram_rdata  in  32  from controller
- sdram_valid  in  4  ID pulse: rdata valid
- sdram_complete  in  4  ID pulse: transaction complete

Behaviour:
- Reset (async, reset_n low): state=IDLE. All outputs 0. The round-robin pointer last_grant is set to NUM_MASTERS-1, so master 0 has top priority first. Reset mid-transaction drops sdram_request immediately and no ack is issued.
- State machine:
  - IDLE: if any m_req is set, pick the first requesting index scanning last_grant+1, last_grant+2, ... with wrap-around. Register that master's write/address/wdata/byte_en/burst onto the sdram_* outputs, set sdram_master=index+1, sdram_request=1, last_grant=index, and go to BUSY. If no m_req is set, stay in IDLE with request 0.
  - BUSY: hold all sdram_* outputs constant. When sdram_complete equals the granted ID, register sdram_request=0 and go to RELEASE.
  - RELEASE: exactly one cycle with request 0 and no arbitration, then go to IDLE.
- Grant latency: m_req high in IDLE gives sdram_request high 1 cycle later.
- Fairness: back-to-back turnaround is 2 cycles (RELEASE, IDLE). The last-granted master has lowest priority at the next arbitration.
- Capture: master fields are captured at grant. Changes on m_* while BUSY are ignored. Captured wdata/byte_en remain stable through the cycle after complete, which the controller's delayed upper-half write needs.
- Ack:
  - m_ack[i] is registered and pulses 1 cycle after sdram_complete == i+1 while BUSY with grant i.
  - The master drops m_req no later than the cycle after it sees m_ack. RELEASE guarantees that the stale request is not re-granted.
- Read return:
  - m_rvalid[i] and m_rdata are registered 1 cycle after sdram_valid == i+1.
  - m_rdata = sdram_rdata, captured only when sdram_valid != 0; otherwise it holds its previous value.
  - Burst reads give 8 m_rvalid pulses. The final pulse may arrive after m_ack; this is legal.
- Writes: the controller also pulses sdram_valid for a write. This is forwarded as m_rvalid, and masters ignore it on writes.
- Stray/illegal IDs:
  - sdram_complete that is non-zero but not the granted ID, or arrives outside BUSY: ignored, no ack, state unchanged.
  - sdram_valid equal to 0 or greater than NUM_MASTERS: no m_rvalid.
- Simultaneous events: sdram_complete in the same cycle as new m_req from other masters is fine; the new requests are arbitrated in the next IDLE. m_req dropped while BUSY is a protocol violation; the arbiter still completes and acks.
- Reads always drive sdram_byte_en as captured; the controller uses the lower half.

Test Plan:
- Reset then m_req=4'b0001, read of 0x0000100 -> sdram_request=1, sdram_master=1, address 0x0000100 one cycle later; stimulate complete=1 -> m_ack[0] one cycle later, request low, 2-cycle RELEASE/IDLE gap.
- m_req=4'b1111 held, each acked → grant order is masters 0,1,2,3,0 (IDs 1,2,3,4,1); no master is granted twice in a row while others request.
- Burst read by master 2: 8 pulses of sdram_valid=3 with data 0x11111111..0x88888888 -> 8 m_rvalid[2] pulses with matching m_rdata, each delayed 1 cycle; no m_rvalid on other masters.
- Write by master 1 of wdata 0xDEADBEEF, byte_en 4'b1100; master changes m_wdata after grant -> sdram_wdata stays 0xDEADBEEF until RELEASE.
- In BUSY with grant ID 2, inject sdram_complete=3 and sdram_valid=0 -> no ack, still BUSY; then complete=2 -> m_ack[1].
- Assert reset_n low mid-BUSY -> sdram_request=0 immediately, all m_ack/m_rvalid=0; after release, master 0 wins first.
